// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Purpose  : Arbitrates one memory port between I-cache and D-cache line
//            requests. Fixed data priority by default; round-robin between the
//            two requesters when the ARB_RR_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [31:0]       inst_address,
  input  logic              inst_read,
  output logic              inst_resp,
  output logic [LINE_W-1:0] inst_rdata,

  input  logic [31:0]       data_address,
  input  logic [LINE_W-1:0] data_wdata,
  input  logic              data_read,
  input  logic              data_write,
  output logic              data_resp,
  output logic [LINE_W-1:0] data_rdata,

  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_line_write,
  input  logic [LINE_W-1:0] mem_line_read,
  input  logic              mem_resp,

  output logic              arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INST    = 2'd1,
    S_DATA    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  logic                data_req;
  logic                grant_data;

  assign data_req = data_read | data_write;

`ifdef ARB_RR_EN
  // Data wins a tie only if instruction side owned the previous grant.
  assign grant_data = data_req & (~inst_read | (last_grant_q == OWNER_INST));
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d      = S_DATA;
          last_grant_d = OWNER_DATA;
          addr_d       = data_address;
          wdata_d      = data_wdata;
          // A simultaneous read+write is serviced as a write only.
          wr_d         = data_write;
          rd_d         = data_read & ~data_write;
        end else if (inst_read) begin
          state_d      = S_INST;
          last_grant_d = OWNER_INST;
          addr_d       = inst_address;
          wdata_d      = '0;
          wr_d         = 1'b0;
          rd_d         = 1'b1;
        end
      end
      S_INST, S_DATA: begin
        if (mem_resp) begin
          state_d = S_RECOVER;
          addr_d  = '0;
          wdata_d = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= OWNER_INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_line_write = wdata_q;
  assign arb_busy       = (state_q != S_IDLE);

  assign inst_resp  = (state_q == S_INST) & mem_resp;
  assign data_resp  = (state_q == S_DATA) & mem_resp;
  assign inst_rdata = inst_resp ? mem_line_read : '0;
  assign data_rdata = data_resp ? mem_line_read : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_rr
// Purpose  : Directed vector table plus multi-cycle sequences for mem_arbiter_rr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       inst_address;
  logic              inst_read;
  logic              inst_resp;
  logic [LINE_W-1:0] inst_rdata;
  logic [31:0]       data_address;
  logic [LINE_W-1:0] data_wdata;
  logic              data_read;
  logic              data_write;
  logic              data_resp;
  logic [LINE_W-1:0] data_rdata;
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_line_write;
  logic [LINE_W-1:0] mem_line_read;
  logic              mem_resp;
  logic              arb_busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter_rr #(.LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .inst_address(inst_address), .inst_read(inst_read),
    .inst_resp(inst_resp), .inst_rdata(inst_rdata),
    .data_address(data_address), .data_wdata(data_wdata),
    .data_read(data_read), .data_write(data_write),
    .data_resp(data_resp), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_line_write(mem_line_write), .mem_line_read(mem_line_read),
    .mem_resp(mem_resp), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ir, dr, dw;
    logic [31:0]       ia, da;
    logic [LINE_W-1:0] wd, line;
    int                lat;
    logic              own_data;
    logic              exp_rd, exp_wr;
    logic [31:0]       exp_addr;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    inst_read  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = tbl[k];
    inst_read    = v.ir;
    data_read    = v.dr;
    data_write   = v.dw;
    inst_address = v.ia;
    data_address = v.da;
    data_wdata   = v.wd;
    chk($sformatf("v%0d idle_busy", k), LINE_W'(arb_busy), '0);
    step();
    chk($sformatf("v%0d mem_read", k), LINE_W'(mem_read), LINE_W'(v.exp_rd));
    chk($sformatf("v%0d mem_write", k), LINE_W'(mem_write), LINE_W'(v.exp_wr));
    chk($sformatf("v%0d mem_address", k), LINE_W'(mem_address), LINE_W'(v.exp_addr));
    chk($sformatf("v%0d busy", k), LINE_W'(arb_busy), LINE_W'(1));
    chk($sformatf("v%0d early_resp", k), LINE_W'({inst_resp, data_resp}), '0);
    if (v.exp_wr) chk($sformatf("v%0d mem_line_write", k), mem_line_write, v.wd);
    for (int i = 1; i < v.lat; i++) begin
      step();
      chk($sformatf("v%0d hold_cmd%0d", k, i), LINE_W'({mem_read, mem_write}), LINE_W'({v.exp_rd, v.exp_wr}));
    end
    mem_resp      = 1'b1;
    mem_line_read = v.line;
    #1;
    chk($sformatf("v%0d inst_resp", k), LINE_W'(inst_resp), LINE_W'(!v.own_data));
    chk($sformatf("v%0d data_resp", k), LINE_W'(data_resp), LINE_W'(v.own_data));
    chk($sformatf("v%0d inst_rdata", k), inst_rdata, v.own_data ? '0 : v.line);
    chk($sformatf("v%0d data_rdata", k), data_rdata, v.own_data ? v.line : '0);
    step();
    mem_resp = 1'b0;
    drop_reqs();
    #1;
    chk($sformatf("v%0d recover_cmd", k), LINE_W'({mem_read, mem_write}), '0);
    chk($sformatf("v%0d recover_busy", k), LINE_W'(arb_busy), LINE_W'(1));
    chk($sformatf("v%0d recover_resp", k), LINE_W'({inst_resp, data_resp}), '0);
    step();
    chk($sformatf("v%0d back_idle", k), LINE_W'(arb_busy), '0);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_5a, pat_be, pat_c3;
    logic              exp_seq [4];
    logic              own;
    int                wait_cnt;

    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    pat_be = {8{32'hDEAD_BEEF}};
    pat_c3 = {32{8'hC3}};

    //           ir    dr    dw    ia            da            wd      line    lat own   rd    wr    addr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0,        '0,     pat_be, 3, 1'b0, 1'b1, 1'b0, 32'h0000_1000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_2040, pat_a5, pat_c3, 2, 1'b1, 1'b0, 1'b1, 32'h0000_2040};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3000, '0,     pat_5a, 1, 1'b1, 1'b1, 1'b0, 32'h0000_3000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_4080, pat_5a, pat_a5, 2, 1'b1, 1'b0, 1'b1, 32'h0000_4080};
`ifdef ARB_RR_EN
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_7000, '0,    pat_c3, 1, 1'b0, 1'b1, 1'b0, 32'h0000_6000};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_9000, '0,    pat_be, 2, 1'b1, 1'b1, 1'b0, 32'h0000_9000};
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_7000, '0,    pat_c3, 1, 1'b1, 1'b1, 1'b0, 32'h0000_7000};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_9000, '0,    pat_be, 2, 1'b1, 1'b1, 1'b0, 32'h0000_9000};
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    rst = 1'b0;
    drop_reqs();
    inst_address  = '0;
    data_address  = '0;
    data_wdata    = '0;
    mem_line_read = '0;
    mem_resp      = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    chk("reset_busy", LINE_W'(arb_busy), '0);
    chk("reset_cmd", LINE_W'({mem_read, mem_write}), '0);
    chk("reset_addr", LINE_W'(mem_address), '0);
    step();

    for (int k = 0; k < 6; k++) run_vec(k);

    // Requester address change after grant must not reach memory.
    data_address = 32'h0000_5000;
    data_read    = 1'b1;
    step();
    data_address = 32'hFFFF_FFC0;
    step();
    chk("latched_addr", LINE_W'(mem_address), LINE_W'(32'h0000_5000));
    chk("latched_rd", LINE_W'(mem_read), LINE_W'(1));
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    drop_reqs();
    step();

    // Reset mid-INST: transaction abandoned, no response.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    inst_address = 32'h0000_A000;
    inst_read    = 1'b1;
    step();
    step();
    chk("pre_rst_rd", LINE_W'(mem_read), LINE_W'(1));
    rst = 1'b0;
    step();
    mem_resp = 1'b1;
    inst_read = 1'b0;
    #1;
    chk("rst_mid_busy", LINE_W'(arb_busy), '0);
    chk("rst_mid_cmd", LINE_W'({mem_read, mem_write}), '0);
    chk("rst_mid_addr", LINE_W'(mem_address), '0);
    chk("rst_mid_resp", LINE_W'({inst_resp, data_resp}), '0);
    chk("rst_mid_rdata", inst_rdata, '0);
    mem_resp = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Both requesters held continuously from reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    inst_address = 32'h0000_B000;
    data_address = 32'h0000_C000;
    inst_read    = 1'b1;
    data_read    = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_cnt = 0;
      step();
      while (!(mem_read | mem_write) && wait_cnt < 10) begin
        step();
        wait_cnt++;
      end
      chk($sformatf("held_g%0d_timeout", g), LINE_W'(wait_cnt < 10), LINE_W'(1));
      own = exp_seq[g];
      chk($sformatf("held_g%0d_addr", g), LINE_W'(mem_address),
          own ? LINE_W'(32'h0000_C000) : LINE_W'(32'h0000_B000));
      mem_resp = 1'b1;
      #1;
      chk($sformatf("held_g%0d_owner", g), LINE_W'({inst_resp, data_resp}), LINE_W'({!own, own}));
      step();
      mem_resp = 1'b0;
      #1;
      chk($sformatf("held_g%0d_recover", g), LINE_W'({mem_read, mem_write}), '0);
    end
    drop_reqs();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
